// File: rtl/pe_result_collector.sv
// pe_result_collector: drains finished sums from a row of pe lanes.
// Each lane's 36-bit sum is latched on its calc_done pulse, then pending
// results are serialized lowest-lane-first onto one valid/ready stream,
// tagged with the lane index.
// Optional feature macro: COLLECTOR_SAT16_EN. When defined, each word is
// arithmetic-shifted right by SHIFT, saturated to signed 16 bits and
// sign-extended back to 36 bits; otherwise the raw sum is passed through.
module pe_result_collector #(
   parameter int N_LANES = 4,
   parameter int IDX_W   = 2,
   parameter int SHIFT   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [36*N_LANES-1:0]   sum_in,
   input  logic [N_LANES-1:0]      calc_done_in,
   output logic [35:0]             out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overflow,
   output logic                    busy
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] LOAD     = 2'd1;
   localparam logic [1:0] WAIT_ACK = 2'd2;

   logic [1:0]         state;
   logic [35:0]        hold [N_LANES];
   logic [N_LANES-1:0] pending;

   logic [IDX_W-1:0]   sel_idx;
   logic [35:0]        sel_word;
   logic [N_LANES-1:0] sel_mask;
   logic [35:0]        load_value;
   logic               load_now;
   logic [N_LANES-1:0] clear_mask;
   logic [N_LANES-1:0] capture;
   logic [N_LANES-1:0] cap_mask;
   logic               ovf_hit;

   // Priority encoder: pick the lowest pending lane and its held word.
   always_comb begin
      sel_idx  = '0;
      sel_word = '0;
      sel_mask = '0;
      for (int k = N_LANES - 1; k >= 0; k--) begin
         if (pending[k]) begin
            sel_idx     = IDX_W'(k);
            sel_word    = hold[k];
            sel_mask    = '0;
            sel_mask[k] = 1'b1;
         end
      end
   end

`ifdef COLLECTOR_SAT16_EN
   logic signed [35:0] shifted;

   // Scale the selected word down and clamp it into the signed 16-bit range.
   always_comb begin
      shifted = $signed(sel_word) >>> SHIFT;
      if (shifted > 36'sd32767)
         load_value = 36'h0_0000_7FFF;
      else if (shifted < -36'sd32768)
         load_value = 36'hF_FFFF_8000;
      else
         load_value = shifted;
   end
`else
   // Raw passthrough of the selected lane's sum.
   always_comb begin
      load_value = sel_word;
   end
`endif

   // A load happens from IDLE directly (giving two-cycle latency) or from LOAD
   // after a completed handshake; both act identically when work is pending.
   always_comb begin
      load_now   = en && (|pending) && ((state == IDLE) || (state == LOAD));
      clear_mask = load_now ? sel_mask : '0;
      capture    = en ? calc_done_in : '0;
      cap_mask   = capture & (~pending | clear_mask);
      ovf_hit    = |(capture & pending & ~clear_mask);
   end

   // Per-lane holding registers and pending flags; a lane being loaded this
   // cycle may be refilled in the same cycle without counting as overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         overflow <= 1'b0;
         for (int k = 0; k < N_LANES; k++) hold[k] <= '0;
      end else begin
         pending <= (pending & ~clear_mask) | cap_mask;
         if (ovf_hit) overflow <= 1'b1;
         for (int k = 0; k < N_LANES; k++) begin
            if (cap_mask[k]) hold[k] <= sum_in[36*k +: 36];
         end
      end
   end

   // Output FSM: load a word, hold it until accepted, then fetch the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_data  <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE, LOAD: begin
               if (|pending) begin
                  out_data  <= load_value;
                  out_idx   <= sel_idx;
                  out_valid <= 1'b1;
                  state     <= WAIT_ACK;
               end else begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            WAIT_ACK: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= (|pending) ? LOAD : IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign busy = (|pending) | out_valid;

endmodule

// File: tb/tb_pe_result_collector.sv
// tb_pe_result_collector: scoreboard bench for pe_result_collector.
// Expected words are queued when stimulus is driven and checked as the
// stream hands them off. Define COLLECTOR_SAT16_EN to exercise saturation.
module tb_pe_result_collector;

   localparam int N_LANES = 4;
   localparam int IDX_W   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  en;
   logic [36*N_LANES-1:0] sum_in;
   logic [N_LANES-1:0]    calc_done_in;
   logic [35:0]           out_data;
   logic [IDX_W-1:0]      out_idx;
   logic                  out_valid;
   logic                  out_ready;
   logic                  overflow;
   logic                  busy;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [35:0]      data;
   } word_t;

   word_t sb[$];
   int    vec_count = 0;
   int    err_count = 0;

   pe_result_collector #(.N_LANES(N_LANES), .IDX_W(IDX_W), .SHIFT(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sum_in(sum_in),
      .calc_done_in(calc_done_in), .out_data(out_data), .out_idx(out_idx),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
      .busy(busy)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vec_count++;
      if (observed !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Expected word contents as the downstream stage should see them.
   function automatic logic [35:0] modelData(input logic [35:0] raw);
`ifdef COLLECTOR_SAT16_EN
      logic signed [35:0] v;
      v = $signed(raw) >>> 8;
      if (v > 36'sd32767) return 36'h0_0000_7FFF;
      if (v < -36'sd32768) return 36'hF_FFFF_8000;
      return v;
`else
      return raw;
`endif
   endfunction

   function automatic logic [36*N_LANES-1:0] packSum(input int lane,
                                                     input logic [35:0] val);
      logic [36*N_LANES-1:0] r;
      r = '0;
      r[36*lane +: 36] = val;
      return r;
   endfunction

   task automatic pushExpected(input int lane, input logic [35:0] data);
      word_t w;
      w.idx  = IDX_W'(lane);
      w.data = data;
      sb.push_back(w);
   endtask

   // Drive one calc_done pulse (caller sits just after a rising edge).
   task automatic applyStimulus(input logic [N_LANES-1:0] done,
                                input logic [36*N_LANES-1:0] sums);
      sum_in       = sums;
      calc_done_in = done;
      @(posedge clk);
      #1;
      calc_done_in = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      checkOutput("drain", 64'(sb.size()), 64'd0);
   endtask

   // Scoreboard monitor: every accepted word must match the queue head.
   always @(negedge clk) begin
      if (rst_n && en && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_word", 64'(out_data), 64'hDEAD);
         end else begin
            word_t w;
            w = sb.pop_front();
            checkOutput("word_idx", 64'(out_idx), 64'(w.idx));
            checkOutput("word_data", 64'(out_data), 64'(w.data));
         end
      end
   end

   initial begin
      logic [6:0] pattern;
      rst_n        = 1'b0;
      en           = 1'b1;
      sum_in       = '0;
      calc_done_in = '0;
      out_ready    = 1'b1;

      // Reset state
      #12;
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_overflow", 64'(overflow), 64'd0);
      checkOutput("rst_data", 64'(out_data), 64'd0);
      checkOutput("rst_idx", 64'(out_idx), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single lane, two-cycle latency
      pushExpected(2, modelData(36'h0_0000_0064));
      applyStimulus(4'b0100, packSum(2, 36'h0_0000_0064));
      @(negedge clk);
      checkOutput("single_valid_early", 64'(out_valid), 64'd0);
      checkOutput("single_busy", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("single_valid", 64'(out_valid), 64'd1);
      checkOutput("single_idx", 64'(out_idx), 64'd2);
      tick();
      @(negedge clk);
      checkOutput("single_busy_after", 64'(busy), 64'd0);

      // Simultaneous lanes 0,1,3: lowest first, one word per two cycles
      tick();
      pushExpected(0, modelData(36'h11));
      pushExpected(1, modelData(36'h22));
      pushExpected(3, modelData(36'h33));
      applyStimulus(4'b1011, packSum(0, 36'h11) | packSum(1, 36'h22) |
                             packSum(3, 36'h33));
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         pattern[6-i] = out_valid;
      end
      checkOutput("simul_valid_pattern", 64'(pattern), 64'(7'b0101010));
      checkOutput("simul_overflow", 64'(overflow), 64'd0);
      waitDrain(20);

      // Backpressure: word stays put while out_ready is low
      tick();
      out_ready = 1'b0;
      pushExpected(1, modelData(36'h77));
      applyStimulus(4'b0010, packSum(1, 36'h77));
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_word", {out_valid, 25'd0, out_idx, out_data},
                     {1'b1, 25'd0, 2'd1, modelData(36'h77)});
      end
      tick();
      out_ready = 1'b1;
      waitDrain(20);

      // Overflow: lane0 refires while still pending behind a stalled word
      tick();
      out_ready = 1'b0;
      pushExpected(1, modelData(36'h9));
      applyStimulus(4'b0010, packSum(1, 36'h9));
      pushExpected(0, modelData(36'h5));
      applyStimulus(4'b0001, packSum(0, 36'h5));
      applyStimulus(4'b0001, packSum(0, 36'h6));
      @(negedge clk);
      checkOutput("ovf_set", 64'(overflow), 64'd1);
      tick();
      out_ready = 1'b1;
      waitDrain(20);
      tick();
      @(negedge clk);
      checkOutput("ovf_sticky", 64'(overflow), 64'd1);

      // Enable low: handshake frozen, done pulses lost
      tick();
      out_ready = 1'b0;
      pushExpected(1, modelData(36'h21));
      applyStimulus(4'b0010, packSum(1, 36'h21));
      @(negedge clk);
      @(negedge clk);
      checkOutput("en_valid_before", 64'(out_valid), 64'd1);
      tick();
      en = 1'b0;
      out_ready = 1'b1;
      applyStimulus(4'b0100, packSum(2, 36'h12));
      @(negedge clk);
      @(negedge clk);
      checkOutput("en_frozen", {out_valid, 25'd0, out_idx, out_data},
                  {1'b1, 25'd0, 2'd1, modelData(36'h21)});
      tick();
      en = 1'b1;
      waitDrain(20);
      tick();
      @(negedge clk);
      checkOutput("en_lost_pulse_busy", 64'(busy), 64'd0);

      // Asynchronous reset in the middle of a transfer
      tick();
      out_ready = 1'b0;
      applyStimulus(4'b1000, packSum(3, 36'h44));
      @(negedge clk);
      @(negedge clk);
      checkOutput("arst_valid_before", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", 64'(out_valid), 64'd0);
      checkOutput("arst_overflow", 64'(overflow), 64'd0);
      checkOutput("arst_busy", 64'(busy), 64'd0);
      checkOutput("arst_data", 64'(out_data), 64'd0);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("arst_quiet", 64'(busy), 64'd0);

`ifdef COLLECTOR_SAT16_EN
      // Saturation and sign handling
      tick();
      pushExpected(0, 36'h0_0000_7FFF);
      applyStimulus(4'b0001, packSum(0, 36'h0_0100_0000));
      waitDrain(20);
      tick();
      pushExpected(2, 36'hF_FFFF_FFFF);
      applyStimulus(4'b0100, packSum(2, 36'hF_FFFF_FF00));
      waitDrain(20);
`endif

      tick();
      checkOutput("final_queue", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
- Back-end drain for a row of pe instances; the counterpart to the stimulus feeder that pushes activations/weights into the row.
- Captures each lane's 36-bit sum on that lane's calc_done pulse and holds it per lane.
- Serializes pending results lowest-lane-first onto a single valid/ready stream, tagged with lane index, for the downstream softmax/writeback stage.

Parameters:
- N_LANES, 4, number of pe lanes observed (1..16).
- IDX_W, 2, width of lane index output; must satisfy 2^IDX_W >= N_LANES.
- SHIFT, 8, arithmetic right-shift applied before saturation (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; when low, no capture and no state change; outputs hold.
- sum_in  input  36*N_LANES  concatenated pe sums; lane k at [36k+35:36k].
- calc_done_in  input  N_LANES  per-lane one-cycle done pulse from pe.
- out_data  output  36  result word.
- out_idx  output  IDX_W  lane index of out_data.
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- overflow  output  1  sticky: a lane completed while its previous result was still pending.
- busy  output  1  high when any lane is pending or out_valid is high.

Behaviour:
- Reset (async, rst_n low): all holding regs = 0, pending[] = 0, out_data = 0, out_idx = 0, out_valid = 0, overflow = 0, FSM = IDLE. Takes effect mid-transfer; any in-flight word is discarded.
- Capture, per lane k, on a clk edge with en=1 and calc_done_in[k]=1:
  - pending[k]=0: hold[k] <= sum_in lane k; pending[k] <= 1.
  - pending[k]=1 and lane k is not being loaded to output this cycle: new value dropped; overflow <= 1 (sticky until reset).
  - pending[k]=1 and lane k is being loaded to output this cycle: new value captured and pending[k] stays 1; no overflow.
- FSM states:
  - IDLE: out_valid=0. If any pending, go to LOAD.
  - LOAD: select lowest k with pending[k]=1. out_data <= hold[k], out_idx <= k, pending[k] cleared (unless re-captured this cycle), out_valid <= 1. Go to WAIT_ACK.
  - WAIT_ACK: out_data/out_idx/out_valid stable while out_ready=0. On out_ready=1: transfer completes. If other pending, go to LOAD, else go to IDLE with out_valid <= 0.
- Throughput and latency:
  - Peak rate is one word per 2 cycles (LOAD, then WAIT_ACK).
  - Latency from calc_done to out_valid is 2 cycles from IDLE: capture edge, then LOAD edge.
- en=0 freezes FSM, pending[] and captures; calc_done pulses during en=0 are lost. out_valid holds its value, and a handshake with out_ready is not completed while en=0.
- Arithmetic: without the optional feature, out_data is the raw 36-bit sum, no modification.
- busy = (|pending) | out_valid, combinational from registers.

Optional Feature:
- Macro COLLECTOR_SAT16_EN.
- Defined: at LOAD, value = hold[k] arithmetic-shifted right by SHIFT (signed 36-bit), saturated to the signed 16-bit range [-32768, 32767], then sign-extended to 36 bits on out_data.
- Undefined: raw 36-bit passthrough; SHIFT unused.

Test Plan:
- Single lane: pulse calc_done_in[2] with lane2 sum=36'h0_0000_0064, out_ready=1 -> out_valid rises 2 cycles later, out_idx=2, out_data=36'h000000064; busy falls the cycle after the handshake.
- Simultaneous: lanes 0,1,3 done in the same cycle with sums 0x11, 0x22, 0x33, out_ready=1 -> words emitted in order idx 0,1,3 with matching data, one word per 2 cycles; overflow stays 0.
- Backpressure: hold out_ready=0 for 5 cycles with lane1 pending -> out_data/out_idx stable, out_valid=1 throughout; released on out_ready=1.
- Overflow: lane0 done (0x5), then lane0 done again (0x6) while still pending and stalled -> overflow=1 sticky, emitted word is 0x5, no 0x6 emitted.
- Reset mid-transfer: assert rst_n=0 while out_valid=1 -> out_valid, overflow, busy go 0 immediately, without waiting for a clock edge; no word emitted after release.
- COLLECTOR_SAT16_EN, SHIFT=8: sum=36'h0_0100_0000 -> out_data=36'h0_0000_7FFF; sum=36'hF_FFFF_FF00 -> out_data=36'hF_FFFF_FFFF.
